// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and access-size decode for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } lsu_size_e;

  // Unknown width codes fall back to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SzByte;
      F3_H, F3_HU: f3_size = SzHalf;
      default:     f3_size = SzWord;
    endcase
  endfunction

  function automatic logic f3_bad(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_B, F3_BU: f3_bad = 1'b0;
      F3_H, F3_HU: f3_bad = lane[0];
      F3_W:        f3_bad = (lane != 2'b00);
      default:     f3_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extract with sign/zero extension and store lane merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] rword,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = rword[{lane, 3'b000} +: 8];
    half_v    = rword[{lane[1], 4'b0000} +: 16];
    load_data = rword;
    merged    = wdata;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    load_data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = rword;
    endcase
    case (f3_size(funct3))
      SzByte: begin
        merged = rword;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SzHalf: begin
        merged = rword;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores by read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN returns resp_err for misaligned or illegal-width requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;

  logic [MEM_AW+1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   wword_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merged;
  logic              accept;
  logic              trap_bad;

  // Address bits above the memory window wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[XLEN-1:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign trap_bad = f3_bad(req_funct3, req_addr[1:0]);
  assign resp_err = err_q && (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= trap_bad;
    end
  end
`else
  assign trap_bad = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign mem_we     = (state_q == WR);
  assign mem_addr   = {{(XLEN-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
  assign mem_wdata  = wword_q;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3   (f3_q),
    .lane     (addr_q[1:0]),
    .rword    (mem_rdata),
    .wdata    (wdata_q),
    .load_data(load_data),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (trap_bad) begin
            state_d = RESP;
          end else if (req_we && (f3_size(req_funct3) == SzWord)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr[MEM_AW+1:0];
        f3_q    <= req_funct3;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wword_q <= req_wdata;
        if (trap_bad) begin
          rdata_q <= '0;
        end
      end
      if (state_q == RD) begin
        if (we_q) begin
          wword_q <= merged;
        end else begin
          rdata_q <= load_data;
        end
      end
      if (state_q == WR) begin
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a comb-read / posedge-write word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];

  int n_checks;
  int n_errors;

  load_store_unit #(
    .XLEN  (32),
    .MEM_AW(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic unused_mem_addr;
  assign unused_mem_addr = ^mem_addr[31:10];
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request; report result, edges from accept to resp_valid and mem_we cycles seen.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat,
                      output int pulses, output logic err);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat    = 0;
    pulses = 0;
    rd     = 32'hxxxx_xxxx;
    err    = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (mem_we) pulses++;
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) check("resp_timeout", 32'(lat), 32'd1);
    @(posedge clk);
    #1;
    check("resp_pulse_len", {31'd0, resp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  int          pulses;
  logic        err;
  int          seen_resp;

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    n_checks   = 0;
    n_errors   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[7] = 32'h80F0_1020;

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xact(1'b0, 3'b010, 32'h1C, 32'h0, rd, lat, pulses, err);
    check("lw_data", rd, 32'h80F0_1020);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_no_we", 32'(pulses), 32'd0);

    xact(1'b0, 3'b000, 32'h1F, 32'h0, rd, lat, pulses, err);
    check("lb_data", rd, 32'hFFFF_FF80);
    xact(1'b0, 3'b100, 32'h1F, 32'h0, rd, lat, pulses, err);
    check("lbu_data", rd, 32'h0000_0080);
    xact(1'b0, 3'b001, 32'h1E, 32'h0, rd, lat, pulses, err);
    check("lh_data", rd, 32'hFFFF_80F0);
    xact(1'b0, 3'b101, 32'h1C, 32'h0, rd, lat, pulses, err);
    check("lhu_data", rd, 32'h0000_1020);

    xact(1'b1, 3'b000, 32'h1D, 32'h0000_00AB, rd, lat, pulses, err);
    check("sb_word", mem[7], 32'h80F0_AB20);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_we_pulses", 32'(pulses), 32'd1);
    check("sb_rdata", rd, 32'd0);

    xact(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, rd, lat, pulses, err);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_pulses", 32'(pulses), 32'd1);
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, lat, pulses, err);
    check("sw_lw_data", rd, 32'hDEAD_BEEF);

    xact(1'b1, 3'b001, 32'h22, 32'h0000_1234, rd, lat, pulses, err);
    check("sh_word", mem[8], 32'h1234_BEEF);

    // Address above the 4 KiB window aliases to word 7.
    xact(1'b0, 3'b010, 32'h0000_101C, 32'h0, rd, lat, pulses, err);
    check("wrap_lw_data", rd, 32'h80F0_AB20);

    // Reset while the SB is in its write cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h1C;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_wr", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we_drop", {31'd0, mem_we}, 32'd0);
    seen_resp = 0;
    @(posedge clk);
    #1;
    if (resp_valid) seen_resp++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen_resp++;
    end
    check("abort_no_resp", 32'(seen_resp), 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_word", mem[7], 32'h80F0_AB20);

    xact(1'b0, 3'b010, 32'h1E, 32'h0, rd, lat, pulses, err);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_no_we", 32'(pulses), 32'd0);
`else
    check("mis_err", {31'd0, err}, 32'd0);
    check("mis_rdata", rd, 32'h80F0_AB20);
    check("mis_lat", 32'(lat), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
